// File: rtl/puf_eval_scheduler.sv
// puf_eval_scheduler: runs N_EVAL evaluations per challenge, sums the XOR votes and logs one word per challenge; PUF_EVAL_RAW_LOG_EN also logs the last raw response first
module puf_eval_scheduler #(
  parameter int CHALLENGE_WIDTH = 32,
  parameter int RESPONSE_WIDTH  = 6,
  parameter int N_EVAL          = 100,
  parameter int N_CHAL          = 64,
  parameter int DONE_TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CHALLENGE_WIDTH-1:0] challenge_in,
  output logic                       chal_ack,
  output logic [CHALLENGE_WIDTH-1:0] puf_challenge,
  output logic                       puf_trigger,
  input  logic                       puf_done,
  input  logic                       puf_xor,
  input  logic [RESPONSE_WIDTH-1:0]  puf_raw,
  output logic                       mem_we,
  output logic [12:0]                mem_waddr,
  output logic [7:0]                 mem_din,
  output logic                       busy,
  output logic                       run_done,
  output logic                       timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT, WRITE, FINISH, ERR} state_t;
`ifdef PUF_EVAL_RAW_LOG_EN
  localparam bit RAW_LOG = 1'b1;
  logic [7:0] raw_ext;
  assign raw_ext = 8'(puf_raw);
`else
  localparam bit RAW_LOG = 1'b0;
  logic [7:0] raw_ext;
  logic unused_raw;
  assign raw_ext = 8'd0;
  assign unused_raw = ^puf_raw;
`endif
  state_t                     state_q;
  logic [7:0]                 eval_cnt_q, sum_q, din_q;
  logic [11:0]                chal_cnt_q;
  logic [15:0]                wait_cnt_q;
  logic [12:0]                waddr_q;
  logic [CHALLENGE_WIDTH-1:0] chal_q;
  logic                       ack_q, trig_q, we_q, done_q, err_q, busy_q, ph_q;
  logic [7:0]                 sum_d;
  assign sum_d = sum_q + {7'd0, puf_xor};
  assign chal_ack      = ack_q;
  assign puf_challenge = chal_q;
  assign puf_trigger   = trig_q;
  assign mem_we        = we_q;
  assign mem_waddr     = waddr_q;
  assign mem_din       = din_q;
  assign busy          = busy_q;
  assign run_done      = done_q;
  assign timeout_err   = err_q;
  // Sequencer: every output is registered and set on the transition into the state it belongs to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      eval_cnt_q <= '0;
      sum_q      <= '0;
      din_q      <= '0;
      chal_cnt_q <= '0;
      wait_cnt_q <= '0;
      waddr_q    <= '0;
      chal_q     <= '0;
      ack_q      <= 1'b0;
      trig_q     <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ph_q       <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      trig_q <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort && busy_q) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ERR: if (start && !abort) begin
            waddr_q    <= '0;
            chal_cnt_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b1;
            state_q    <= LOAD;
          end
          LOAD: begin
            chal_q     <= challenge_in;
            sum_q      <= '0;
            eval_cnt_q <= '0;
            trig_q     <= 1'b1;
            state_q    <= TRIG;
          end
          TRIG: begin
            wait_cnt_q <= '0;
            state_q    <= WAIT;
          end
          WAIT: if (puf_done) begin
            sum_q <= sum_d;
            din_q <= RAW_LOG ? raw_ext : sum_d;
            ph_q  <= 1'b0;
            if (eval_cnt_q == 8'(N_EVAL - 1)) begin
              we_q    <= 1'b1;
              state_q <= WRITE;
            end else begin
              eval_cnt_q <= eval_cnt_q + 8'd1;
              trig_q     <= 1'b1;
              state_q    <= TRIG;
            end
          end else if (wait_cnt_q == 16'(DONE_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
          WRITE: begin
            waddr_q <= waddr_q + 13'd1;
            if (RAW_LOG && !ph_q) begin
              ph_q  <= 1'b1;
              din_q <= sum_q;
              we_q  <= 1'b1;
            end else if (chal_cnt_q == 12'(N_CHAL - 1)) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              chal_cnt_q <= chal_cnt_q + 12'd1;
              ack_q      <= 1'b1;
              state_q    <= LOAD;
            end
          end
          FINISH: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_puf_eval_scheduler.sv
// tb_puf_eval_scheduler: table-driven runs with a write scoreboard plus timeout, abort and reset sequences
module tb_puf_eval_scheduler;
  typedef struct {
    logic [7:0] pat;
    logic [5:0] raw;
    logic [7:0] s0;
    logic [7:0] s1;
  } vec_t;
  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;
`ifdef PUF_EVAL_RAW_LOG_EN
  localparam int WPC = 2;
`else
  localparam int WPC = 1;
`endif
  logic        clk, reset_n, start, abort, puf_done, puf_xor;
  logic [31:0] challenge_in, puf_challenge;
  logic [5:0]  puf_raw;
  logic        chal_ack, puf_trigger, mem_we, busy, run_done, timeout_err;
  logic [12:0] mem_waddr;
  logic [7:0]  mem_din;
  int          n_chk, n_fail, n_trig, n_ack, n_done, eidx;
  logic [7:0]  pat;
  logic        resp_en;
  logic [1:0]  sh;
  logic [31:0] chal_exp;
  vec_t        vecs [0:4];
  wr_t         exp_q [$];

  puf_eval_scheduler #(
    .CHALLENGE_WIDTH(32), .RESPONSE_WIDTH(6), .N_EVAL(4), .N_CHAL(2), .DONE_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .challenge_in(challenge_in), .chal_ack(chal_ack), .puf_challenge(puf_challenge),
    .puf_trigger(puf_trigger), .puf_done(puf_done), .puf_xor(puf_xor), .puf_raw(puf_raw),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din), .busy(busy),
    .run_done(run_done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, score writes, then drive the responder
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    if (mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(mem_we), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_waddr), 32'(e.a));
        chk("wr_data", 32'(mem_din), 32'(e.d));
      end
    end
    if (puf_trigger) chk("puf_challenge", puf_challenge, chal_exp);
    if (chal_ack) chal_exp = challenge_in;
    if (puf_trigger) challenge_in = $urandom;
    n_trig += int'(puf_trigger);
    n_ack  += int'(chal_ack);
    n_done += int'(run_done);
    puf_done = resp_en && sh[1];
    puf_xor  = puf_done ? pat[3'(eidx)] : 1'b0;
    if (puf_done) eidx++;
    sh = {sh[0], puf_trigger};
  endtask

  task automatic first_word(vec_t v);
`ifdef PUF_EVAL_RAW_LOG_EN
    exp_q.push_back('{13'd0, {2'b00, v.raw}});
`else
    exp_q.push_back('{13'd0, v.s0});
`endif
  endtask

  task automatic push_run(vec_t v);
    for (int c = 0; c < 2; c++) begin
`ifdef PUF_EVAL_RAW_LOG_EN
      exp_q.push_back('{13'(2 * c), {2'b00, v.raw}});
      exp_q.push_back('{13'(2 * c + 1), (c == 0) ? v.s0 : v.s1});
`else
      exp_q.push_back('{13'(c), (c == 0) ? v.s0 : v.s1});
`endif
    end
  endtask

  task automatic begin_run(vec_t v, logic en);
    pat = v.pat; puf_raw = v.raw; resp_en = en; eidx = 0; sh = 2'b00;
    n_trig = 0; n_ack = 0; n_done = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_vec(int k);
    push_run(vecs[k]);
    begin_run(vecs[k], 1'b1);
    chk("busy_at_start", 32'(busy), 32'd1);
    chk("err_cleared", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (run_done) break;
    end
    chk("run_done_seen", 32'(run_done), 32'd1);
    chk("waddr_final", 32'(mem_waddr), 32'(2 * WPC));
    cyc();
    chk("busy_after", 32'(busy), 32'd0);
    chk("run_done_pulses", 32'(n_done), 32'd1);
    chk("trigger_count", 32'(n_trig), 32'd8);
    chk("ack_count", 32'(n_ack), 32'd2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("no_err", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int wcnt;
    logic seen_trig;
    n_chk = 0; n_fail = 0; n_trig = 0; n_ack = 0; n_done = 0; eidx = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; puf_done = 1'b0; puf_xor = 1'b0;
    puf_raw = '0; resp_en = 1'b0; sh = 2'b00; pat = '0;
    challenge_in = 32'hC0FF_EE01; chal_exp = '0;
    vecs[0] = '{8'h8D, 6'h2A, 8'd3, 8'd1};
    vecs[1] = '{8'hFF, 6'h2A, 8'd4, 8'd4};
    vecs[2] = '{8'h00, 6'h15, 8'd0, 8'd0};
    vecs[3] = '{8'hF0, 6'h3F, 8'd0, 8'd4};
    vecs[4] = '{8'hA7, 6'h01, 8'd3, 8'd2};
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_din", 32'(mem_din), 32'd0);
    chk("rst_chal", puf_challenge, 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) run_vec(k);
    // Silent PUF: timeout after DONE_TIMEOUT wait cycles, no write
    begin_run(vecs[0], 1'b0);
    wcnt = 0; seen_trig = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (timeout_err) break;
      if (seen_trig && busy && !puf_trigger) wcnt++;
      if (puf_trigger) seen_trig = 1'b1;
    end
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_wait_cycles", 32'(wcnt), 32'd8);
    chk("err_not_busy", 32'(busy), 32'd0);
    repeat (3) cyc();
    chk("err_sticky", 32'(timeout_err), 32'd1);
    chk("err_triggers", 32'(n_trig), 32'd1);
    run_vec(1);
    // Abort in the second wait of the first challenge
    begin_run(vecs[1], 1'b1);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (n_trig == 2) break;
    end
    chk("abort_reached_trig2", 32'(n_trig), 32'd2);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    repeat (20) cyc();
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_no_trig", 32'(n_trig), 32'd2);
    chk("abort_one_ack", 32'(n_ack), 32'd1);
    n_ack = 0;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    repeat (3) cyc();
    chk("start_abort_no_ack", 32'(n_ack), 32'd0);
    // Reset pulse while a write is on the bus
    first_word(vecs[4]);
    begin_run(vecs[4], 1'b1);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (mem_we) break;
    end
    chk("reset_reached_write", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    chk("mid_rst_din", 32'(mem_din), 32'd0);
    chk("mid_rst_chal", puf_challenge, 32'd0);
    chk("mid_rst_pulses", {28'd0, puf_trigger, chal_ack, run_done, timeout_err}, 32'd0);
    cyc();
    reset_n = 1'b1; resp_en = 1'b0; sh = 2'b00;
    repeat (5) cyc();
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
    run_vec(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/puf_eval_scheduler.md
PUF_EVAL_SCHEDULER -- requirements
Module: puf_eval_scheduler

Interface
REQ-001 SHALL have parameter CHALLENGE_WIDTH, default 32, PUF challenge width.
REQ-002 SHALL have parameter RESPONSE_WIDTH, default 6, raw PUF response width.
REQ-003 SHALL have parameter N_EVAL, default 100, evaluations per challenge; legal range 1..255.
REQ-004 SHALL have parameter N_CHAL, default 64, challenges per run; legal range 1..4096.
REQ-005 SHALL have parameter DONE_TIMEOUT, default 255, maximum wait cycles for puf_done.
REQ-006 SHALL have the following ports:
  clk  in  1  single clock.
  reset_n  in  1  asynchronous, active-low reset.
  start  in  1  one-cycle run request.
  abort  in  1  synchronous run cancel.
  challenge_in  in  CHALLENGE_WIDTH  next challenge from the challenge generator.
  chal_ack  out  1  one-cycle pulse when challenge_in is consumed.
  puf_challenge  out  CHALLENGE_WIDTH  challenge applied to the PUF core.
  puf_trigger  out  1  one-cycle evaluation strobe to the PUF core.
  puf_done  in  1  PUF core evaluation complete.
  puf_xor  in  1  PUF XOR response bit.
  puf_raw  in  RESPONSE_WIDTH  PUF raw response.
  mem_we  out  1  result memory write enable.
  mem_waddr  out  13  result memory write address.
  mem_din  out  8  result memory write data.
  busy  out  1  high in any state other than IDLE or ERR.
  run_done  out  1  one-cycle pulse at end of run.
  timeout_err  out  1  sticky timeout flag.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, TRIG, WAIT, WRITE, FINISH and ERR; all outputs SHALL be registered.
REQ-008 IDLE: when start=1 and abort=0, SHALL clear mem_waddr to 0, the challenge counter and timeout_err, then go to LOAD; start SHALL be ignored in all other states.
REQ-009 LOAD: SHALL latch challenge_in into puf_challenge, pulse chal_ack for exactly 1 cycle, clear sum and the evaluation counter, then go to TRIG.
REQ-010 TRIG: SHALL assert puf_trigger for exactly 1 cycle, clear the wait counter, then go to WAIT.
REQ-011 WAIT: SHALL sample puf_done on every cycle.
  - On puf_done=1: SHALL set sum <= sum + puf_xor and latch puf_raw; if eval_cnt == N_EVAL-1, go to WRITE; otherwise increment eval_cnt and go to TRIG.
  - puf_done asserted in the cycle TRIG is entered SHALL NOT be counted.
REQ-012 WAIT timeout: if puf_done stays 0 for DONE_TIMEOUT consecutive cycles, SHALL set timeout_err=1, go to ERR, and perform no write.
REQ-013 sum SHALL be 8 bits and, given N_EVAL<=255, SHALL never overflow.
REQ-014 WRITE: SHALL hold mem_we=1 for 1 cycle with mem_din=sum at the current mem_waddr; mem_waddr SHALL increment after each write and wrap 8191->0.
REQ-015 After WRITE: if chal_cnt == N_CHAL-1, SHALL go to FINISH; otherwise increment chal_cnt and go to LOAD.
REQ-016 FINISH: SHALL pulse run_done for 1 cycle and return to IDLE; mem_waddr SHALL then hold the count of words written.
REQ-017 ERR: SHALL hold timeout_err=1 and busy=0; start SHALL clear the error and begin a new run as in IDLE.
REQ-018 abort=1 in any busy state SHALL return the FSM to IDLE on the next edge with no further write, trigger or ack; abort SHALL win over start when both are asserted together.
REQ-019 mem_we, puf_trigger, chal_ack and run_done SHALL be 0 in every state except the state named for each.

Reset
REQ-020 reset_n=0 SHALL asynchronously force:
  - state IDLE;
  - all counters, sum, puf_challenge, mem_waddr and mem_din to 0;
  - all 1-bit outputs to 0.
REQ-021 Reset asserted mid-run SHALL abort the run without completing a pending write.

Configuration
REQ-022 When macro PUF_EVAL_RAW_LOG_EN is defined:
  - WRITE SHALL occupy 2 cycles: first {2'b0, last puf_raw[5:0]}, then sum, at consecutive addresses;
  - each run SHALL produce 2*N_CHAL words.
REQ-023 When PUF_EVAL_RAW_LOG_EN is undefined, puf_raw SHALL be ignored and one word per challenge SHALL be written.

Verification (N_EVAL=4, N_CHAL=2, DONE_TIMEOUT=8, macro undefined unless stated)
REQ-024 Responder returns puf_done 2 cycles after each trigger with puf_xor=1,0,1,1 then 0,0,0,1 -> writes 3 at addr 0 and 1 at addr 1, 8 triggers, 2 chal_ack pulses, run_done pulse, mem_waddr=2.
REQ-025 puf_done never asserted -> timeout_err=1 eight cycles after the first trigger, state ERR, no mem_we; a subsequent start clears timeout_err and restarts at addr 0.
REQ-026 abort on the second WAIT of challenge 1 -> IDLE next cycle, zero writes, run_done stays 0; start and abort asserted together in IDLE -> remains IDLE.
REQ-027 reset_n low for 1 cycle during WRITE -> mem_we=0 immediately, all outputs 0, FSM in IDLE.
REQ-028 Macro defined, puf_raw=6'h2A, all puf_xor=1 -> writes 8'h2A at addr 0, 4 at addr 1, 8'h2A at addr 2, 4 at addr 3, mem_waddr=4.
